z3_autoconfig_host: RTL and testbench
=====================================

// Module: z3_autoconfig_host
// PURPOSE
//  Zorro III AutoConfig initiator: the host side of the config protocol our memory card answers. On start it runs
//  read cycles over config registers 0x00-0x13, decodes the nibbles into board fields, then issues one write:
//  base address (board configured) or shut-up (board rejected). Used by the bench host model and a future
//  accelerator config engine. Handles one board per start; board-to-board chaining is done by the caller.
// PARAMETERS
//  ACK_TIMEOUT  255  CLK cycles to wait for DTACK_n per bus cycle before abort
//  RECOVER      2    CLK cycles FCS_n held high between bus cycles (min 1)
// PORTS
//  CLK        in   1   system clock
//  RESET      in   1   asynchronous, active-high reset
//  start      in   1   one-cycle pulse; begin config of the board in the config slot
//  base_addr  in   4   base nibble written to card (register 0x11)
//  busy       out  1   sequence in progress
//  done       out  1   one-cycle pulse at sequence end
//  status     out  2   0=configured 1=shut-up 2=no board (timeout) 3=bus error (timeout after first ack)
//  er_type    out  8   register 0x00/0x01 raw (not inverted)
//  er_flags   out  8   register 0x04/0x05, de-inverted
//  prod_id    out  8   registers 0x02/0x03, de-inverted
//  mfg_id     out  16  registers 0x08-0x0B, de-inverted
//  serial     out  32  registers 0x0C-0x13, de-inverted
//  ADDRL      out  7   config address; register index i drives ADDRL[5:0]=i[6:1], ADDRL[6]=i[0]
//  FCS_n      out  1   full cycle strobe, low for whole bus cycle
//  DS_n       out  1   data strobe
//  READ       out  1   1=read 0=write
//  FC         out  3   function code; 3'b101 (supervisor data) during cycles, 3'b000 idle
//  DOUT       out  4   write data to card
//  DIN        in   4   read data from card
//  DTACK_n    in   1   card acknowledge
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE, FCS_n=DS_n=1, READ=1, FC=0, ADDRL=0, DOUT=0, busy=done=0, status=0,
//   all decoded fields 0, timeout and recover counters 0. Reset mid-cycle releases strobes in that same event.
//  States: IDLE->ADDR->STROBE->WAIT->SAMPLE->RELEASE->RECOVER->(ADDR | WRITE-path | FINISH)->IDLE.
//  IDLE: start=1 -> busy=1, index=0x00, READ=1, go ADDR. start while busy ignored.
//  ADDR (1 clk): ADDRL/READ/FC/DOUT valid, FCS_n=0. STROBE: DS_n=0, clear timeout counter, go WAIT.
//  WAIT: DTACK_n=0 -> SAMPLE; counter==ACK_TIMEOUT -> abort: strobes high, status=2 if index==0x00 on a read
//   else 3, go FINISH.
//  SAMPLE (1 clk, covers registered card data): reads latch DIN into nibble slot for index; indices 0x00,0x01
//   stored raw, all others stored ~DIN. Indices 0x06,0x07 read but discarded.
//  RELEASE: FCS_n=DS_n=1, FC=0. RECOVER: RECOVER clocks idle, then index+1 for next read until 0x13 done.
//  After index 0x13: er_type[7:6]==2'b10 -> write index 0x22 (ADDRL[5:0]=0x11, ADDRL[6]=0) with DOUT=base_addr,
//   status=0; else write index 0x26 (ADDRL[5:0]=0x13) with DOUT=0, status=1. Write uses same
//   ADDR..RECOVER sequence with READ=0; SAMPLE stores nothing.
//  FINISH: done=1 for exactly one CLK, busy=0 same cycle, go IDLE. Fields/status hold until next start.
//  Latency per cycle w/ immediate DTACK: ADDR+STROBE+WAIT+SAMPLE+RELEASE+RECOVER = 5+RECOVER clocks;
//   full sequence 21 cycles -> 21*(5+RECOVER)+1 clocks.
//  Timeout counter 8-bit saturating compare; never wraps. DTACK_n low while not in WAIT is ignored.
//  FCS_n rises once per bus cycle (card advances its CFGOUT_n on that edge); never glitches within a cycle.
// TESTING
//  Card model mfg 0x07DB, prod 0x72, serial 421, type 0xA4, base 4'hA -> mfg_id=0x07DB prod_id=0x72
//   serial=0x000001A5 er_type=0xA4, write at ADDRL=0x11 READ=0 DOUT=0xA, status=0, done pulse, busy low.
//  Card type 0xC4 (Zorro II) -> write at ADDRL=0x13 DOUT=0, status=1.
//  No DTACK ever, ACK_TIMEOUT=255 -> strobes released 256 clks after STROBE, status=2, one done pulse.
//  DTACK withheld at index 0x0C only -> status=3, no config write issued.
//  RESET asserted with DS_n=0 mid-read -> FCS_n=DS_n=1 immediately, busy=0, fields 0; next start full run.
//  start pulsed at 5 points during busy -> ignored; exactly 21 FCS_n low periods, one done.

Source files
------------

// File: rtl/z3_autoconfig_host.sv
// Zorro III AutoConfig initiator: reads config registers 0x00-0x13 of one board, decodes its
// identity fields, then writes either the base address or shut-up back to the card.
module z3_autoconfig_host #(
    parameter int ACK_TIMEOUT = 255,
    parameter int RECOVER     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [3:0]  base_addr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  er_type,
    output logic [7:0]  er_flags,
    output logic [7:0]  prod_id,
    output logic [15:0] mfg_id,
    output logic [31:0] serial,
    output logic [6:0]  ADDRL,
    output logic        FCS_n,
    output logic        DS_n,
    output logic        READ,
    output logic [2:0]  FC,
    output logic [3:0]  DOUT,
    input  logic [3:0]  DIN,
    input  logic        DTACK_n
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_SAMPLE, S_RELEASE, S_RECOVER, S_FINISH
    } state_t;

    localparam logic [7:0] TO_LIMIT   = 8'(ACK_TIMEOUT);
    localparam logic [7:0] REC_LAST   = 8'(RECOVER - 1);
    localparam logic [6:0] IDX_LAST   = 7'h13;
    localparam logic [6:0] IDX_BASE   = 7'h22;
    localparam logic [6:0] IDX_SHUTUP = 7'h26;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_idx;
    logic       r_wr;
    logic [7:0] r_to_cnt;
    logic [7:0] r_rec_cnt;
    logic       w_in_cycle;
    logic       w_strobe;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Register index i appears on the bus as {i[0], i[6:1]}.
    function automatic logic [6:0] cfg_addr(input logic [6:0] idx);
        return {idx[0], idx[6:1]};
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_ADDR;
            S_ADDR:    w_next = S_STROBE;
            S_STROBE:  w_next = S_WAIT;
            S_WAIT: begin
                if (!DTACK_n)                 w_next = S_SAMPLE;
                else if (r_to_cnt >= TO_LIMIT) w_next = S_FINISH;
            end
            S_SAMPLE:  w_next = S_RELEASE;
            S_RELEASE: w_next = S_RECOVER;
            S_RECOVER: if (r_rec_cnt >= REC_LAST) w_next = r_wr ? S_FINISH : S_ADDR;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they never glitch inside a bus cycle.
    assign w_in_cycle = (w_next == S_ADDR) || (w_next == S_STROBE) ||
                        (w_next == S_WAIT) || (w_next == S_SAMPLE);
    assign w_strobe   = (w_next == S_STROBE) || (w_next == S_WAIT) || (w_next == S_SAMPLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FCS_n     <= 1'b1;
            DS_n      <= 1'b1;
            READ      <= 1'b1;
            FC        <= 3'b000;
            ADDRL     <= 7'd0;
            DOUT      <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= 2'd0;
            er_type   <= 8'd0;
            er_flags  <= 8'd0;
            prod_id   <= 8'd0;
            mfg_id    <= 16'd0;
            serial    <= 32'd0;
            r_idx     <= 7'd0;
            r_wr      <= 1'b0;
            r_to_cnt  <= 8'd0;
            r_rec_cnt <= 8'd0;
        end else begin
            FCS_n <= !w_in_cycle;
            DS_n  <= !w_strobe;
            FC    <= w_in_cycle ? 3'b101 : 3'b000;
            busy  <= (w_next != S_IDLE) && (w_next != S_FINISH);
            done  <= (w_next == S_FINISH);
            case (r_state)
                S_IDLE: if (start) begin
                    r_idx    <= 7'd0;
                    r_wr     <= 1'b0;
                    READ     <= 1'b1;
                    ADDRL    <= cfg_addr(7'd0);
                    DOUT     <= 4'd0;
                    status   <= 2'd0;
                    er_type  <= 8'd0;
                    er_flags <= 8'd0;
                    prod_id  <= 8'd0;
                    mfg_id   <= 16'd0;
                    serial   <= 32'd0;
                end
                S_STROBE: r_to_cnt <= 8'd0;
                S_WAIT: if (DTACK_n) begin
                    if (r_to_cnt >= TO_LIMIT) begin
                        status <= (r_idx == 7'd0 && !r_wr) ? 2'd2 : 2'd3;
                        READ   <= 1'b1;
                    end else begin
                        r_to_cnt <= sat_inc(r_to_cnt);
                    end
                end
                // Card data is inverted except for the er_type pair at 0x00/0x01.
                S_SAMPLE: if (!r_wr) begin
                    case (r_idx)
                        7'h00: er_type[7:4]   <= DIN;
                        7'h01: er_type[3:0]   <= DIN;
                        7'h02: prod_id[7:4]   <= ~DIN;
                        7'h03: prod_id[3:0]   <= ~DIN;
                        7'h04: er_flags[7:4]  <= ~DIN;
                        7'h05: er_flags[3:0]  <= ~DIN;
                        7'h08: mfg_id[15:12]  <= ~DIN;
                        7'h09: mfg_id[11:8]   <= ~DIN;
                        7'h0A: mfg_id[7:4]    <= ~DIN;
                        7'h0B: mfg_id[3:0]    <= ~DIN;
                        7'h0C: serial[31:28]  <= ~DIN;
                        7'h0D: serial[27:24]  <= ~DIN;
                        7'h0E: serial[23:20]  <= ~DIN;
                        7'h0F: serial[19:16]  <= ~DIN;
                        7'h10: serial[15:12]  <= ~DIN;
                        7'h11: serial[11:8]   <= ~DIN;
                        7'h12: serial[7:4]    <= ~DIN;
                        7'h13: serial[3:0]    <= ~DIN;
                        default: ;
                    endcase
                end
                S_RELEASE: r_rec_cnt <= 8'd0;
                S_RECOVER: begin
                    if (r_rec_cnt >= REC_LAST) begin
                        if (r_wr) begin
                            READ <= 1'b1;
                        end else if (r_idx == IDX_LAST) begin
                            r_wr <= 1'b1;
                            READ <= 1'b0;
                            if (er_type[7:6] == 2'b10) begin
                                r_idx  <= IDX_BASE;
                                ADDRL  <= cfg_addr(IDX_BASE);
                                DOUT   <= base_addr;
                                status <= 2'd0;
                            end else begin
                                r_idx  <= IDX_SHUTUP;
                                ADDRL  <= cfg_addr(IDX_SHUTUP);
                                DOUT   <= 4'd0;
                                status <= 2'd1;
                            end
                        end else begin
                            r_idx <= r_idx + 7'd1;
                            ADDRL <= cfg_addr(r_idx + 7'd1);
                        end
                    end else begin
                        r_rec_cnt <= sat_inc(r_rec_cnt);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_z3_autoconfig_host.sv
// Bench for z3_autoconfig_host: a nibble-register card model answers the bus; outcomes are
// predicted from the card's board parameters and the bus-cycle timing rules.
module tb_z3_autoconfig_host;
    localparam int ACK_TO = 255;
    localparam int REC    = 2;
    localparam int CYC    = 5 + REC;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [3:0]  base_addr;
    logic        busy, done;
    logic [1:0]  status;
    logic [7:0]  er_type, er_flags, prod_id;
    logic [15:0] mfg_id;
    logic [31:0] serial;
    logic [6:0]  ADDRL;
    logic        FCS_n, DS_n, READ;
    logic [2:0]  FC;
    logic [3:0]  DOUT, DIN;
    logic        DTACK_n;

    z3_autoconfig_host #(.ACK_TIMEOUT(ACK_TO), .RECOVER(REC)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .status(status), .er_type(er_type),
        .er_flags(er_flags), .prod_id(prod_id), .mfg_id(mfg_id), .serial(serial),
        .ADDRL(ADDRL), .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ), .FC(FC),
        .DOUT(DOUT), .DIN(DIN), .DTACK_n(DTACK_n)
    );

    always #5 CLK = ~CLK;

    // Card model: ack_mode 0 = ack after ack_delay, 1 = never ack, 2 = never ack index 0x0C.
    logic [3:0] card [0:19];
    int         ack_mode  = 0;
    int         ack_delay = 0;
    int         ds_cnt    = 0;
    logic [6:0] cur_idx;

    always_comb begin
        cur_idx = {ADDRL[5:0], ADDRL[6]};
        DIN     = (cur_idx < 7'd20) ? card[cur_idx[4:0]] : 4'h0;
        DTACK_n = 1'b1;
        if (!DS_n && ds_cnt >= ack_delay) begin
            if (ack_mode == 0) DTACK_n = 1'b0;
            else if (ack_mode == 2 && cur_idx != 7'h0C) DTACK_n = 1'b0;
        end
    end

    always @(posedge CLK) ds_cnt <= DS_n ? 0 : ds_cnt + 1;

    // Bus monitor: cumulative counters, read as deltas by the test sequences.
    logic       prev_fcs = 1'b1;
    int         n_fcs = 0, n_wr = 0, n_done = 0, n_dslow = 0, n_busbad = 0;
    logic [6:0] wr_addr = 7'd0;
    logic [3:0] wr_dout = 4'd0;

    always @(posedge CLK) begin
        prev_fcs <= FCS_n;
        if (prev_fcs && !FCS_n) begin
            n_fcs <= n_fcs + 1;
            if (!READ) begin
                n_wr    <= n_wr + 1;
                wr_addr <= ADDRL;
                wr_dout <= DOUT;
            end
        end
        if (done)  n_done  <= n_done + 1;
        if (!DS_n) n_dslow <= n_dslow + 1;
        if ((!FCS_n && FC != 3'b101) || (FCS_n && FC != 3'b000) || (!DS_n && FCS_n))
            n_busbad <= n_busbad + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] mfg;
        logic [7:0]  prod;
        logic [31:0] ser;
        logic [7:0]  typ;
        logic [7:0]  flg;
        logic [3:0]  base;
        int          dly;
        logic [1:0]  exp_status;
        logic [6:0]  exp_addr;
        logic [3:0]  exp_dout;
    } vec_t;

    task automatic load_card(input vec_t v);
        card[0] = v.typ[7:4];
        card[1] = v.typ[3:0];
        card[2] = ~v.prod[7:4];
        card[3] = ~v.prod[3:0];
        card[4] = ~v.flg[7:4];
        card[5] = ~v.flg[3:0];
        card[6] = 4'($urandom);
        card[7] = 4'($urandom);
        for (int k = 0; k < 4; k++) card[8 + k]  = ~v.mfg[15 - 4*k -: 4];
        for (int k = 0; k < 8; k++) card[12 + k] = ~v.ser[31 - 4*k -: 4];
    endtask

    // Pulses start and counts clocks from the edge that accepts it to the edge raising done.
    task automatic run_cfg(input logic [3:0] base, input bit inject, output int clks, output bit got);
        base_addr = base;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        clks = 0;
        got  = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge CLK); #1;
            clks  = c;
            start = inject && (c == 3 || c == 20 || c == 50 || c == 100 || c == 140);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) check("done_timeout", 32'(clks), 32'hFFFF_FFFF);
    endtask

    task automatic do_vec(input vec_t v, input bit inject, input string tag);
        int c0, w0, d0, clks, extra;
        bit got;
        load_card(v);
        ack_mode  = 0;
        ack_delay = v.dly;
        extra     = (v.dly > 1) ? v.dly - 1 : 0;
        c0 = n_fcs; w0 = n_wr; d0 = n_done;
        run_cfg(v.base, inject, clks, got);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_status"},   32'(status),   32'(v.exp_status));
        check({tag, "_er_type"},  32'(er_type),  32'(v.typ));
        check({tag, "_er_flags"}, 32'(er_flags), 32'(v.flg));
        check({tag, "_prod_id"},  32'(prod_id),  32'(v.prod));
        check({tag, "_mfg_id"},   32'(mfg_id),   32'(v.mfg));
        check({tag, "_serial"},   serial,        v.ser);
        check({tag, "_latency"},  32'(clks),     32'(21 * (CYC + extra)));
        @(posedge CLK); #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_cycles"},  32'(n_fcs - c0), 32'd21);
        check({tag, "_writes"},  32'(n_wr - w0),  32'd1);
        check({tag, "_wr_addr"}, 32'(wr_addr),    32'(v.exp_addr));
        check({tag, "_wr_dout"}, 32'(wr_dout),    32'(v.exp_dout));
        check({tag, "_dones"},   32'(n_done - d0), 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        int c0, w0, d0, s0, clks;
        bit got;
        vec_t rv;

        vecs[0] = '{16'h07DB, 8'h72, 32'd421,       8'hA4, 8'h30, 4'hA, 0, 2'd0, 7'h11, 4'hA};
        vecs[1] = '{16'h07DB, 8'h72, 32'd421,       8'hC4, 8'h30, 4'hA, 0, 2'd1, 7'h13, 4'h0};
        vecs[2] = '{16'h1234, 8'h05, 32'hDEADBEEF,  8'h80, 8'hF1, 4'h3, 3, 2'd0, 7'h11, 4'h3};
        vecs[3] = '{16'hFFFF, 8'h00, 32'h0000_0000, 8'h40, 8'h00, 4'h7, 1, 2'd1, 7'h13, 4'h0};

        RESET = 1'b0; start = 1'b0; base_addr = 4'h0;
        for (int k = 0; k < 20; k++) card[k] = 4'h0;
        #2 RESET = 1'b1;
        #2;
        check("rst_fcs_n", 32'(FCS_n), 32'd1);
        check("rst_ds_n",  32'(DS_n),  32'd1);
        check("rst_read",  32'(READ),  32'd1);
        check("rst_fc",    32'(FC),    32'd0);
        check("rst_addrl", 32'(ADDRL), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 4; i++) do_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rv.mfg  = 16'($urandom);
            rv.prod = 8'($urandom);
            rv.ser  = $urandom;
            rv.typ  = 8'($urandom);
            rv.flg  = 8'($urandom);
            rv.base = 4'($urandom);
            rv.dly  = $urandom_range(0, 4);
            rv.exp_status = (rv.typ[7:6] == 2'b10) ? 2'd0 : 2'd1;
            rv.exp_addr   = (rv.exp_status == 2'd0) ? 7'h11 : 7'h13;
            rv.exp_dout   = (rv.exp_status == 2'd0) ? rv.base : 4'h0;
            do_vec(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        do_vec(vecs[0], 1'b1, "start_ignored");

        // No board at all: single read cycle times out.
        ack_mode = 1;
        c0 = n_fcs; w0 = n_wr; d0 = n_done; s0 = n_dslow;
        run_cfg(4'h5, 1'b0, clks, got);
        check("noboard_status",  32'(status), 32'd2);
        check("noboard_latency", 32'(clks),   32'(ACK_TO + 3));
        @(posedge CLK); #1;
        check("noboard_ds_low",  32'(n_dslow - s0), 32'(ACK_TO + 2));
        check("noboard_strobes", 32'({FCS_n, DS_n}), 32'd3);
        check("noboard_cycles",  32'(n_fcs - c0), 32'd1);
        check("noboard_writes",  32'(n_wr - w0),  32'd0);
        check("noboard_dones",   32'(n_done - d0), 32'd1);

        // Card stops answering at serial register 0x0C after acking earlier cycles.
        load_card(vecs[0]);
        ack_mode = 2; ack_delay = 0;
        c0 = n_fcs; w0 = n_wr; d0 = n_done;
        run_cfg(4'hA, 1'b0, clks, got);
        check("buserr_status",  32'(status),  32'd3);
        check("buserr_er_type", 32'(er_type), 32'hA4);
        check("buserr_mfg_id",  32'(mfg_id),  32'h07DB);
        check("buserr_latency", 32'(clks),    32'(12 * CYC + ACK_TO + 3));
        @(posedge CLK); #1;
        check("buserr_cycles",  32'(n_fcs - c0), 32'd13);
        check("buserr_writes",  32'(n_wr - w0),  32'd0);
        check("buserr_dones",   32'(n_done - d0), 32'd1);

        // Asynchronous reset in the middle of a read with DS_n low.
        ack_mode = 0; ack_delay = 4;
        c0 = n_fcs;
        base_addr = 4'hA;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge CLK); #1;
            if ((n_fcs - c0) >= 5 && !DS_n) begin
                got = 1'b1;
                break;
            end
        end
        check("midrst_reached", 32'(got), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("midrst_strobes", 32'({FCS_n, DS_n}), 32'd3);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_fields",  32'(er_type) | 32'(mfg_id) | 32'(prod_id), 32'd0);
        check("midrst_fc",      32'(FC),      32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        do_vec(vecs[0], 1'b0, "after_rst");

        check("bus_protocol", 32'(n_busbad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
